// File: rtl/instr_fetch_sequencer.sv
// Fetch/decode/execute sequencer placed in front of instruction_decoder.
// Owns the PC, fetches words over a req/ack handshake, screens the opcode,
// hands off to the execute stage and counts retirements. Every output is a
// register; the combinational process computes the next value of each one.
module instr_fetch_sequencer #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          IMEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic        exec_start,
    input  logic        exec_done,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] pc,
    output logic [31:0] retired,
    output logic        halted,
    output logic        fault,
    output logic [1:0]  fault_code
);

    localparam int          CNT_W     = $clog2(IMEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IMEM_TIMEOUT - 1);
    localparam logic [31:0] NOP_WORD  = 32'h0000_0013;
    localparam logic [6:0]  OP_SYSTEM = 7'b1110011;

    localparam logic [1:0] CODE_TIMEOUT    = 2'b01;
    localparam logic [1:0] CODE_ILLEGAL    = 2'b10;
    localparam logic [1:0] CODE_MISALIGNED = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_HALT,
        S_FAULT
    } state_t;

    state_t            state, state_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic [31:0]       pc_d, instr_d, retired_d;
    logic              req_d, valid_d, exec_start_d, halted_d, fault_d;
    logic [1:0]        code_d;
    logic              go_fetch;
    logic [31:0]       fetch_pc;

    // Opcodes the execute stage accepts; SYSTEM is handled separately.
    function automatic logic is_legal(input logic [6:0] op);
        case (op)
            7'b0110011, 7'b0010011, 7'b0000011,
            7'b1100111, 7'b0100011, 7'b1100011,
            7'b0110111, 7'b0010111, 7'b1101111: is_legal = 1'b1;
            default:                            is_legal = 1'b0;
        endcase
    endfunction

    assign imem_addr = pc;

    // Next-state and next-output computation for every registered output.
    always_comb begin
        state_d      = state;
        cnt_d        = cnt;
        pc_d         = pc;
        instr_d      = instr;
        retired_d    = retired;
        req_d        = imem_req;
        valid_d      = instr_valid;
        exec_start_d = 1'b0;
        halted_d     = halted;
        fault_d      = fault;
        code_d       = fault_code;
        go_fetch     = 1'b0;
        fetch_pc     = pc;

        case (state)
            S_IDLE: begin
                if (start) begin
                    go_fetch = 1'b1;
                    fetch_pc = pc;
                end
            end
            S_FETCH: begin
                // An ack in the last allowed cycle takes priority over the timeout.
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    cnt_d   = '0;
                    req_d   = 1'b0;
                    valid_d = 1'b1;
                    state_d = S_DECODE;
                end else if (cnt == CNT_LAST) begin
                    cnt_d   = '0;
                    req_d   = 1'b0;
                    fault_d = 1'b1;
                    code_d  = CODE_TIMEOUT;
                    state_d = S_FAULT;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            S_DECODE: begin
                if (is_legal(instr[6:0])) begin
                    exec_start_d = 1'b1;
                    state_d      = S_EXEC;
                end else if (instr[6:0] == OP_SYSTEM) begin
                    valid_d  = 1'b0;
                    halted_d = 1'b1;
                    state_d  = S_HALT;
                end else begin
                    valid_d = 1'b0;
                    fault_d = 1'b1;
                    code_d  = CODE_ILLEGAL;
                    state_d = S_FAULT;
                end
            end
            S_EXEC: begin
                if (exec_done) begin
                    retired_d = retired + 32'd1;
                    valid_d   = 1'b0;
                    go_fetch  = 1'b1;
                    fetch_pc  = branch_taken ? branch_target : pc + 32'd4;
                end
            end
            S_HALT: begin
                if (start) begin
                    halted_d = 1'b0;
                    go_fetch = 1'b1;
                    fetch_pc = pc + 32'd4;
                end
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Entering FETCH: a misaligned PC faults before any request goes out.
        if (go_fetch) begin
            pc_d  = fetch_pc;
            cnt_d = '0;
            if (fetch_pc[1:0] != 2'b00) begin
                fault_d = 1'b1;
                code_d  = CODE_MISALIGNED;
                state_d = S_FAULT;
            end else begin
                req_d   = 1'b1;
                state_d = S_FETCH;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Output and datapath registers; reset clears them immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            pc          <= RESET_PC;
            instr       <= NOP_WORD;
            retired     <= '0;
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
            exec_start  <= 1'b0;
            halted      <= 1'b0;
            fault       <= 1'b0;
            fault_code  <= 2'b00;
        end else begin
            cnt         <= cnt_d;
            pc          <= pc_d;
            instr       <= instr_d;
            retired     <= retired_d;
            imem_req    <= req_d;
            instr_valid <= valid_d;
            exec_start  <= exec_start_d;
            halted      <= halted_d;
            fault       <= fault_d;
            fault_code  <= code_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// Self-checking bench for instr_fetch_sequencer: directed scenarios plus a
// randomized instruction stream compared against a transaction-level model
// of PC, retirement count and fault/halt outcomes.
module tb_instr_fetch_sequencer;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          TMO      = 16;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        exec_start;
    logic        exec_done;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] pc;
    logic [31:0] retired;
    logic        halted;
    logic        fault;
    logic [1:0]  fault_code;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_pc;
    logic [31:0] m_retired;

    logic [6:0] legal_ops [9] = '{7'b0110011, 7'b0010011, 7'b0000011,
                                  7'b1100111, 7'b0100011, 7'b1100011,
                                  7'b0110111, 7'b0010111, 7'b1101111};

    instr_fetch_sequencer #(
        .RESET_PC     (RESET_PC),
        .IMEM_TIMEOUT (TMO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .instr         (instr),
        .instr_valid   (instr_valid),
        .exec_start    (exec_start),
        .exec_done     (exec_done),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .pc            (pc),
        .retired       (retired),
        .halted        (halted),
        .fault         (fault),
        .fault_code    (fault_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic op_legal(input logic [6:0] op);
        logic hit = 1'b0;
        foreach (legal_ops[i]) if (legal_ops[i] == op) hit = 1'b1;
        return hit;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_req"},   imem_req,    0);
        chk({tag, "_addr"},  imem_addr,   RESET_PC);
        chk({tag, "_pc"},    pc,          RESET_PC);
        chk({tag, "_instr"}, instr,       32'h0000_0013);
        chk({tag, "_valid"}, instr_valid, 0);
        chk({tag, "_xs"},    exec_start,  0);
        chk({tag, "_ret"},   retired,     0);
        chk({tag, "_halt"},  halted,      0);
        chk({tag, "_flt"},   fault,       0);
        chk({tag, "_code"},  fault_code,  0);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        chk_reset(tag);
        tick();
        rst_n = 1'b1;
        m_pc = RESET_PC;
        m_retired = 0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_req", imem_req, 1);
        chk("start_addr", imem_addr, m_pc);
    endtask

    task automatic resume_halt();
        start = 1'b1;
        tick();
        start = 1'b0;
        m_pc = m_pc + 32'd4;
        chk("resume_halted", halted, 0);
        chk("resume_req", imem_req, 1);
        chk("resume_addr", imem_addr, m_pc);
    endtask

    // One full instruction: fetch with `waits` stalled cycles, decode, then
    // either execute (exec_done `dly` cycles after exec_start), halt or fault.
    task automatic run_instr(input logic [31:0] word, input int waits, input int dly,
                             input logic br, input logic [31:0] tgt, input logic noise);
        logic [6:0] op;
        op = word[6:0];
        chk("fetch_req", imem_req, 1);
        chk("fetch_addr", imem_addr, m_pc);
        for (int i = 0; i < waits; i++) begin
            if (noise) begin
                exec_done = 1'($urandom_range(0, 1));
                start     = 1'($urandom_range(0, 1));
            end
            tick();
            chk("wait_req", imem_req, 1);
            chk("wait_addr", imem_addr, m_pc);
        end
        exec_done  = 1'b0;
        start      = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = word;
        tick();
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        chk("dec_instr", instr, word);
        chk("dec_valid", instr_valid, 1);
        chk("dec_req", imem_req, 0);
        chk("dec_xs", exec_start, 0);
        tick();
        if (op_legal(op)) begin
            chk("exec_start", exec_start, 1);
            chk("exec_valid", instr_valid, 1);
            for (int i = 0; i < dly; i++) begin
                tick();
                chk("exec_pulse", exec_start, 0);
            end
            exec_done     = 1'b1;
            branch_taken  = br;
            branch_target = tgt;
            tick();
            exec_done     = 1'b0;
            branch_taken  = 1'b0;
            branch_target = $urandom;
            m_retired = m_retired + 32'd1;
            m_pc      = br ? tgt : m_pc + 32'd4;
            chk("ret_count", retired, m_retired);
            chk("ret_pc", pc, m_pc);
            chk("ret_valid", instr_valid, 0);
            if (m_pc[1:0] != 2'b00) begin
                chk("mis_fault", fault, 1);
                chk("mis_code", fault_code, 2'b11);
                chk("mis_req", imem_req, 0);
            end else begin
                chk("next_req", imem_req, 1);
            end
        end else if (op == 7'b1110011) begin
            chk("halt_flag", halted, 1);
            chk("halt_pc", pc, m_pc);
            chk("halt_ret", retired, m_retired);
            chk("halt_req", imem_req, 0);
        end else begin
            chk("ill_fault", fault, 1);
            chk("ill_code", fault_code, 2'b10);
            chk("ill_req", imem_req, 0);
        end
    endtask

    initial begin
        logic [31:0] w;
        logic [31:0] t;
        rst_n = 1'b1;
        start = 1'b0;
        imem_ack = 1'b0;
        imem_rdata = 32'h0;
        exec_done = 1'b0;
        branch_taken = 1'b0;
        branch_target = 32'h0;
        m_pc = RESET_PC;
        m_retired = 0;
        #3;
        do_reset("rst0");

        // Stray ack/done in IDLE must be ignored.
        imem_ack = 1'b1;
        exec_done = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_ack = 1'b0;
        exec_done = 1'b0;
        chk("idle_req", imem_req, 0);
        chk("idle_instr", instr, 32'h0000_0013);

        // Basic fetch/execute, then a taken jump to 0x40.
        do_start();
        run_instr(32'h0050_0093, 2, 1, 1'b0, 32'h0, 1'b0);
        chk("t1_addr", imem_addr, 32'h4);
        chk("t1_instr", instr, 32'h0050_0093);
        run_instr(32'h0000_006F, 0, 0, 1'b1, 32'h40, 1'b0);
        chk("t2_addr", imem_addr, 32'h40);

        // ECALL halts; start resumes at pc+4.
        run_instr(32'h0000_0073, 1, 0, 1'b0, 32'h0, 1'b0);
        tick();
        chk("halt_hold", halted, 1);
        resume_halt();

        // Ack in the final allowed cycle beats the timeout.
        run_instr(32'h0000_0013, TMO - 1, 0, 1'b0, 32'h0, 1'b0);
        chk("late_ack_fault", fault, 0);

        // Randomized instruction stream with stray start/exec_done while stalled.
        for (int n = 0; n < 30; n++) begin
            w = $urandom;
            t = $urandom;
            t[1:0] = 2'b00;
            if ($urandom_range(0, 5) == 0) begin
                w[6:0] = 7'b1110011;
                run_instr(w, $urandom_range(0, 15), 0, 1'b0, 32'h0, 1'b1);
                resume_halt();
            end else begin
                w[6:0] = legal_ops[$urandom_range(0, 8)];
                run_instr(w, $urandom_range(0, 15), $urandom_range(0, 3),
                          1'($urandom_range(0, 1)), t, 1'b1);
            end
        end

        // PC wrap from the top of the address space.
        run_instr(32'h0000_006F, 0, 0, 1'b1, 32'hFFFF_FFFC, 1'b0);
        run_instr(32'h0000_0033, 0, 0, 1'b0, 32'h0, 1'b0);
        chk("wrap_pc", pc, 32'h0);

        // Asynchronous reset while in EXEC.
        imem_ack = 1'b1;
        imem_rdata = 32'h0000_0013;
        tick();
        imem_ack = 1'b0;
        tick();
        chk("pre_rst_xs", exec_start, 1);
        do_reset("rst_exec");

        // Illegal opcode is sticky; start ignored.
        do_start();
        run_instr(32'h0000_007F, 0, 0, 1'b0, 32'h0, 1'b0);
        start = 1'b1;
        tick();
        tick();
        start = 1'b0;
        chk("ill_sticky", fault, 1);
        chk("ill_sticky_code", fault_code, 2'b10);
        chk("ill_sticky_req", imem_req, 0);
        do_reset("rst_ill");

        // Misaligned branch target faults without issuing a request.
        do_start();
        run_instr(32'h0000_0063, 0, 0, 1'b1, 32'h42, 1'b0);
        start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("mis_noreq", imem_req, 0);
        end
        start = 1'b0;
        chk("mis_sticky_code", fault_code, 2'b11);
        do_reset("rst_mis");

        // Fetch timeout: IMEM_TIMEOUT request cycles with no ack.
        do_start();
        for (int i = 1; i < TMO; i++) begin
            tick();
            chk("tmo_req", imem_req, 1);
            chk("tmo_nofault", fault, 0);
        end
        tick();
        chk("tmo_fault", fault, 1);
        chk("tmo_code", fault_code, 2'b01);
        chk("tmo_req_drop", imem_req, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
